ecc_decrypt_seq: RTL and testbench



---
 rtl/ecc_decrypt_seq_pkg.sv | 45 ++++
 rtl/ecc_decrypt_seq_if.sv | 28 ++
 rtl/ecc_decrypt_seq_point_op.sv | 105 ++++++++++
 rtl/ecc_decrypt_seq.sv | 156 +++++++++++++++
 tb/tb_ecc_decrypt_seq.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_decrypt_seq_pkg.sv
// Shared types and GF(2^4) helpers for the ECC decryption datapath.
// Imported by the interface, the point-operation unit and the top level.
package ecc_pkg;

  localparam int FIELD_W = 4;
  localparam int POLY_W  = 5;
  localparam int BIT_W   = $clog2(FIELD_W);

  typedef logic [FIELD_W-1:0] fe_t;
  typedef logic [POLY_W-1:0]  poly_t;

  typedef struct packed {
    fe_t  x;
    fe_t  y;
    logic inf;
  } point_t;

  typedef enum logic [2:0] {IDLE, LOAD, DBL, ADD, FINAL} state_t;
  typedef enum logic {OP_DBL, OP_ADD} op_t;
  typedef enum logic [1:0] {PH_IDLE, PH_X, PH_Y} phase_t;
  typedef enum logic [1:0] {RES_O, RES_P, RES_DBL, RES_ADD} res_kind_t;

  localparam point_t POINT_O = '{x: '0, y: '0, inf: 1'b1};

  // Shift-and-add multiply; the shifted operand is reduced by f whenever it overflows.
  function automatic fe_t gf_mul(fe_t a, fe_t b, poly_t f);
    fe_t   acc;
    poly_t sh;
    acc = '0;
    sh  = {1'b0, a};
    for (int i = 0; i < FIELD_W; i++) begin
      if (b[i]) acc = acc ^ sh[FIELD_W-1:0];
      sh = sh << 1;
      if (sh[FIELD_W]) sh = sh ^ f;
    end
    return acc;
  endfunction

  function automatic fe_t gf_reduce_a(poly_t a, poly_t f);
    poly_t t;
    t = a[POLY_W-1] ? (a ^ f) : a;
    return t[FIELD_W-1:0];
  endfunction

endpackage

// File: rtl/ecc_decrypt_seq_if.sv
// Request/response bundle between a ciphertext source and the decryptor.
interface ecc_decrypt_seq_if;

  logic              start;
  ecc_pkg::fe_t      c1x;
  ecc_pkg::fe_t      c1y;
  ecc_pkg::fe_t      c2x;
  ecc_pkg::fe_t      c2y;
  ecc_pkg::fe_t      d;
  ecc_pkg::poly_t    a;
  ecc_pkg::poly_t    f;
  ecc_pkg::fe_t      mx;
  ecc_pkg::fe_t      my;
  logic              valid;
  logic              busy;
  logic              inf;

  modport master (
    output start, c1x, c1y, c2x, c2y, d, a, f,
    input  mx, my, valid, busy, inf
  );

  modport slave (
    input  start, c1x, c1y, c2x, c2y, d, a, f,
    output mx, my, valid, busy, inf
  );

endinterface

// File: rtl/ecc_decrypt_seq_point_op.sv
// Three-cycle point double/add unit: lambda, then x3, then y3 with done.
// Operands must stay stable from start until done.
module ecc_point_op
  import ecc_pkg::*;
(
  input  logic   clock,
  input  logic   rst_n,
  input  logic   start,
  input  op_t    op,
  input  point_t r,
  input  fe_t    px,
  input  fe_t    py,
  input  fe_t    a_r,
  input  poly_t  f,
  output logic   done,
  output point_t result
);

  phase_t    phase_q, phase_d;
  res_kind_t kind_q, kind_d;
  fe_t       l_q, l_d;
  fe_t       x3_q, x3_d;

  fe_t  num, den, lam, y3_dbl, y3_add;
  logic same_x, same_y, use_dbl;

  // x^14 = x^8 * x^4 * x^2, which also maps 0 to 0.
  function automatic fe_t gf_inv(fe_t x, poly_t fp);
    fe_t x2, x4, x8;
    x2 = gf_mul(x, x, fp);
    x4 = gf_mul(x2, x2, fp);
    x8 = gf_mul(x4, x4, fp);
    return gf_mul(gf_mul(x8, x4, fp), x2, fp);
  endfunction

  always_comb begin
    phase_d = phase_q;
    kind_d  = kind_q;
    l_d     = l_q;
    x3_d    = x3_q;
    done    = 1'b0;
    result  = POINT_O;

    same_x  = (r.x == px);
    same_y  = (r.y == py);
    use_dbl = (op == OP_DBL) || (same_x && same_y);

    if (use_dbl) begin
      num = r.y;
      den = r.x;
    end else begin
      num = r.y ^ py;
      den = r.x ^ px;
    end
    lam = gf_mul(num, gf_inv(den, f), f) ^ (use_dbl ? r.x : fe_t'(0));

    y3_dbl = gf_mul(r.x, r.x, f) ^ gf_mul(l_q ^ fe_t'(1), x3_q, f);
    y3_add = gf_mul(l_q, r.x ^ x3_q, f) ^ x3_q ^ r.y;

    case (phase_q)
      PH_IDLE: begin
        if (start) begin
          phase_d = PH_X;
          l_d     = lam;
          if (r.inf)            kind_d = (op == OP_DBL) ? RES_O : RES_P;
          else if (use_dbl)     kind_d = (r.x == '0) ? RES_O : RES_DBL;
          else if (same_x)      kind_d = RES_O;
          else                  kind_d = RES_ADD;
        end
      end
      PH_X: begin
        x3_d    = gf_mul(l_q, l_q, f) ^ l_q ^ a_r ^
                  ((kind_q == RES_ADD) ? (r.x ^ px) : fe_t'(0));
        phase_d = PH_Y;
      end
      PH_Y: begin
        done    = 1'b1;
        phase_d = PH_IDLE;
      end
      default: phase_d = PH_IDLE;
    endcase

    case (kind_q)
      RES_P:   result = '{x: px,   y: py,     inf: 1'b0};
      RES_DBL: result = '{x: x3_q, y: y3_dbl, inf: 1'b0};
      RES_ADD: result = '{x: x3_q, y: y3_add, inf: 1'b0};
      default: result = POINT_O;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      kind_q  <= RES_O;
      l_q     <= '0;
      x3_q    <= '0;
    end else begin
      phase_q <= phase_d;
      kind_q  <= kind_d;
      l_q     <= l_d;
      x3_q    <= x3_d;
    end
  end

endmodule

// File: rtl/ecc_decrypt_seq.sv
// Recovers M = C2 xor d*C1 with a constant-time double-and-add ladder.
// Every bit performs a double and an add; the add is only committed when d[i]=1.
module ecc_decrypt_seq
  import ecc_pkg::*;
(
  input  logic clock,
  input  logic rst_n,
  ecc_decrypt_seq_if.slave bus
);

  state_t             state_q, state_d;
  logic [1:0]         sub_q, sub_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  point_t             acc_q, acc_d;
  fe_t                c1x_q, c1x_d, c1y_q, c1y_d;
  fe_t                c2x_q, c2x_d, c2y_q, c2y_d;
  fe_t                d_q, d_d, ar_q, ar_d;
  poly_t              f_q, f_d;
  fe_t                mx_q, mx_d, my_q, my_d;
  logic               inf_q, inf_d, valid_q, valid_d;

  logic   op_start, op_done;
  op_t    op_sel;
  point_t op_res;

  ecc_point_op u_point_op (
    .clock  (clock),
    .rst_n  (rst_n),
    .start  (op_start),
    .op     (op_sel),
    .r      (acc_q),
    .px     (c1x_q),
    .py     (c1y_q),
    .a_r    (ar_q),
    .f      (f_q),
    .done   (op_done),
    .result (op_res)
  );

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    bit_d    = bit_q;
    acc_d    = acc_q;
    c1x_d    = c1x_q;
    c1y_d    = c1y_q;
    c2x_d    = c2x_q;
    c2y_d    = c2y_q;
    d_d      = d_q;
    ar_d     = ar_q;
    f_d      = f_q;
    mx_d     = mx_q;
    my_d     = my_q;
    inf_d    = inf_q;
    valid_d  = 1'b0;
    op_start = 1'b0;
    op_sel   = OP_DBL;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          c1x_d   = bus.c1x;
          c1y_d   = bus.c1y;
          c2x_d   = bus.c2x;
          c2y_d   = bus.c2y;
          d_d     = bus.d;
          f_d     = bus.f;
          ar_d    = gf_reduce_a(bus.a, bus.f);
          state_d = LOAD;
        end
      end
      LOAD: begin
        acc_d   = POINT_O;
        bit_d   = BIT_W'(FIELD_W - 1);
        sub_d   = '0;
        state_d = DBL;
      end
      DBL: begin
        op_sel   = OP_DBL;
        op_start = (sub_q == 2'd0);
        sub_d    = sub_q + 2'd1;
        if (op_done) begin
          acc_d   = op_res;
          sub_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        op_sel   = OP_ADD;
        op_start = (sub_q == 2'd0);
        sub_d    = sub_q + 2'd1;
        if (op_done) begin
          if (d_q[bit_q]) acc_d = op_res;
          sub_d = '0;
          if (bit_q == '0) begin
            state_d = FINAL;
          end else begin
            bit_d   = bit_q - 1'b1;
            state_d = DBL;
          end
        end
      end
      FINAL: begin
        mx_d    = c2x_q ^ (acc_q.inf ? fe_t'(0) : acc_q.x);
        my_d    = c2y_q ^ (acc_q.inf ? fe_t'(0) : acc_q.y);
        inf_d   = acc_q.inf;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sub_q   <= '0;
      bit_q   <= '0;
      acc_q   <= POINT_O;
      c1x_q   <= '0;
      c1y_q   <= '0;
      c2x_q   <= '0;
      c2y_q   <= '0;
      d_q     <= '0;
      ar_q    <= '0;
      f_q     <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      inf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      bit_q   <= bit_d;
      acc_q   <= acc_d;
      c1x_q   <= c1x_d;
      c1y_q   <= c1y_d;
      c2x_q   <= c2x_d;
      c2y_q   <= c2y_d;
      d_q     <= d_d;
      ar_q    <= ar_d;
      f_q     <= f_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      inf_q   <= inf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.mx    = mx_q;
  assign bus.my    = my_q;
  assign bus.inf   = inf_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ecc_decrypt_seq.sv
// Randomised self-checking bench for ecc_decrypt_seq against a curve-arithmetic model.
module tb_ecc_decrypt_seq;

  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  ecc_decrypt_seq_if bus();

  ecc_decrypt_seq dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    bit         inf;
  } mpt_t;

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_mul(input logic [3:0] x, input logic [3:0] y, input logic [4:0] f);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (y[i]) p ^= 8'(x) << i;
    for (int k = 7; k >= 4; k--) if (p[k]) p ^= 8'(f) << (k - 4);
    return p[3:0];
  endfunction

  function automatic logic [3:0] m_inv(input logic [3:0] x, input logic [4:0] f);
    for (int v = 1; v < 16; v++) if (m_mul(x, 4'(v), f) == 4'h1) return 4'(v);
    return 4'h0;
  endfunction

  function automatic mpt_t m_zero();
    mpt_t o;
    o.x = 4'h0; o.y = 4'h0; o.inf = 1'b1;
    return o;
  endfunction

  function automatic mpt_t m_dbl(input mpt_t p, input logic [3:0] a, input logic [4:0] f);
    mpt_t o;
    logic [3:0] l;
    if (p.inf || p.x == 4'h0) return m_zero();
    l = p.x ^ m_mul(p.y, m_inv(p.x, f), f);
    o.x = m_mul(l, l, f) ^ l ^ a;
    o.y = m_mul(p.x, p.x, f) ^ m_mul(l ^ 4'h1, o.x, f);
    o.inf = 1'b0;
    return o;
  endfunction

  function automatic mpt_t m_add(input mpt_t r, input mpt_t p, input logic [3:0] a, input logic [4:0] f);
    mpt_t o;
    logic [3:0] l;
    if (p.inf) return r;
    if (r.inf) return p;
    if (r.x == p.x) return (r.y == p.y) ? m_dbl(r, a, f) : m_zero();
    l = m_mul(r.y ^ p.y, m_inv(r.x ^ p.x, f), f);
    o.x = m_mul(l, l, f) ^ l ^ r.x ^ p.x ^ a;
    o.y = m_mul(l, r.x ^ o.x, f) ^ o.x ^ r.y;
    o.inf = 1'b0;
    return o;
  endfunction

  function automatic mpt_t m_smul(input logic [3:0] k, input mpt_t p, input logic [3:0] a, input logic [4:0] f);
    mpt_t r;
    r = m_zero();
    for (int i = 3; i >= 0; i--) begin
      r = m_dbl(r, a, f);
      if (k[i]) r = m_add(r, p, a, f);
    end
    return r;
  endfunction

  function automatic logic [3:0] m_ar(input logic [4:0] a, input logic [4:0] f);
    logic [4:0] t;
    t = a[4] ? (a ^ f) : a;
    return t[3:0];
  endfunction

  // Returns {mx, my, inf}.
  function automatic logic [8:0] expect_out(input logic [3:0] c1x, c1y, c2x, c2y, d,
                                            input logic [4:0] a, f);
    mpt_t c1, s;
    c1.x = c1x; c1.y = c1y; c1.inf = 1'b0;
    s = m_smul(d, c1, m_ar(a, f), f);
    return {c2x ^ (s.inf ? 4'h0 : s.x), c2y ^ (s.inf ? 4'h0 : s.y), s.inf};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic [3:0] c1x, c1y, c2x, c2y, d, input logic [4:0] a, f);
    bus.c1x = c1x; bus.c1y = c1y; bus.c2x = c2x; bus.c2y = c2y;
    bus.d = d; bus.a = a; bus.f = f;
  endtask

  task automatic set_random();
    logic [4:0] f;
    case ($urandom_range(0, 2))
      0:       f = 5'h13;
      1:       f = 5'h19;
      default: f = 5'h1F;
    endcase
    set_in(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 5'($urandom), f);
  endtask

  // Expects start=1 already driven; returns edges from capture to valid (bounded).
  task automatic launch_and_wait(output int cycles);
    @(posedge clock);
    #1 bus.start = 1'b0;
    cycles = 0;
    do begin
      @(posedge clock);
      #1;
      cycles++;
    end while (!bus.valid && cycles < 60);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h00, 5'h13);
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if ({bus.mx, bus.my, bus.valid, bus.busy, bus.inf} !== 11'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %h expected 000", {bus.mx, bus.my, bus.valid, bus.busy, bus.inf});
    end
    rst_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_vectors();
    logic [3:0] vc1x[3] = '{4'hF, 4'h6, 4'h0};
    logic [3:0] vc1y[3] = '{4'hF, 4'hB, 4'h7};
    logic [3:0] vc2x[3] = '{4'hE, 4'h5, 4'h9};
    logic [3:0] vc2y[3] = '{4'h3, 4'hA, 4'h6};
    logic [3:0] vd[3]   = '{4'h1, 4'h0, 4'h2};
    logic [8:0] vexp[3] = '{{4'h1, 4'hC, 1'b0}, {4'h5, 4'hA, 1'b1}, {4'h9, 4'h6, 1'b1}};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      set_in(vc1x[i], vc1y[i], vc2x[i], vc2y[i], vd[i], 5'h10, 5'h13);
      bus.start = 1'b1;
      launch_and_wait(cyc);
      tests_run++;
      if (cyc !== 26) begin
        tests_failed++;
        $display("[TB] FAIL vec%0d_latency: got %0d expected 26", i, cyc);
      end
      tests_run++;
      if ({bus.mx, bus.my, bus.inf} !== vexp[i]) begin
        tests_failed++;
        $display("[TB] FAIL vec%0d_result: got %h expected %h", i, {bus.mx, bus.my, bus.inf}, vexp[i]);
      end
      @(posedge clock);
      #1;
      tests_run++;
      if ({bus.valid, bus.mx, bus.my, bus.inf} !== {1'b0, vexp[i]}) begin
        tests_failed++;
        $display("[TB] FAIL vec%0d_pulse_hold: got %h expected %h", i, {bus.valid, bus.mx, bus.my, bus.inf}, {1'b0, vexp[i]});
      end
    end
  endtask

  task automatic test_round_trip();
    logic [3:0] ks[4] = '{4'd1, 4'd2, 4'd3, 4'd8};
    logic [3:0] ds[4] = '{4'd3, 4'd1, 4'd2, 4'd10};
    mpt_t p, q, c1, s;
    int cyc;
    p.x = 4'hF; p.y = 4'hF; p.inf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q  = m_smul(ds[i], p, 4'h3, 5'h13);
      c1 = m_smul(ks[i], p, 4'h3, 5'h13);
      s  = m_smul(ks[i], q, 4'h3, 5'h13);
      set_in(c1.x, c1.y, 4'h1 ^ (s.inf ? 4'h0 : s.x), 4'hC ^ (s.inf ? 4'h0 : s.y),
             ds[i], 5'h10, 5'h13);
      bus.start = 1'b1;
      launch_and_wait(cyc);
      tests_run++;
      if ({bus.mx, bus.my} !== 8'h1C || cyc !== 26) begin
        tests_failed++;
        $display("[TB] FAIL round_trip_d%0d_k%0d: got m=%h lat=%0d expected m=1c lat=26",
                 ds[i], ks[i], {bus.mx, bus.my}, cyc);
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] exp;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      set_random();
      exp = expect_out(bus.c1x, bus.c1y, bus.c2x, bus.c2y, bus.d, bus.a, bus.f);
      bus.start = 1'b1;
      launch_and_wait(cyc);
      tests_run++;
      if ({bus.mx, bus.my, bus.inf} !== exp || cyc !== 26) begin
        tests_failed++;
        $display("[TB] FAIL random%0d: got %h lat=%0d expected %h lat=26",
                 i, {bus.mx, bus.my, bus.inf}, cyc, exp);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [8:0] exp;
    int cyc, vcount;
    set_random();
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midop_busy: got %b expected 1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.mx, bus.my, bus.valid, bus.busy, bus.inf} !== 11'h0) begin
      tests_failed++;
      $display("[TB] FAIL midop_reset_outputs: got %h expected 000", {bus.mx, bus.my, bus.valid, bus.busy, bus.inf});
    end
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    vcount = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.valid || bus.busy) vcount++;
    end
    tests_run++;
    if (vcount !== 0) begin
      tests_failed++;
      $display("[TB] FAIL midop_no_valid: got %0d active cycles expected 0", vcount);
    end
    set_random();
    exp = expect_out(bus.c1x, bus.c1y, bus.c2x, bus.c2y, bus.d, bus.a, bus.f);
    bus.start = 1'b1;
    launch_and_wait(cyc);
    tests_run++;
    if ({bus.mx, bus.my, bus.inf} !== exp || cyc !== 26) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_op: got %h lat=%0d expected %h lat=26", {bus.mx, bus.my, bus.inf}, cyc, exp);
    end
  endtask

  task automatic test_start_while_busy();
    logic [8:0] exp;
    int cyc;
    set_in(4'hF, 4'hF, 4'hE, 4'h3, 4'h1, 5'h10, 5'h13);
    exp = expect_out(4'hF, 4'hF, 4'hE, 4'h3, 4'h1, 5'h10, 5'h13);
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
      if (cyc == 5) begin
        set_in(4'h3, 4'h9, 4'h0, 4'h0, 4'hB, 5'h07, 5'h19);
        bus.start = 1'b1;
      end else if (cyc == 6) begin
        bus.start = 1'b0;
      end
    end while (!bus.valid && cyc < 60);
    tests_run++;
    if ({bus.mx, bus.my, bus.inf} !== exp || cyc !== 26) begin
      tests_failed++;
      $display("[TB] FAIL busy_start_ignored: got %h lat=%0d expected %h lat=26", {bus.mx, bus.my, bus.inf}, cyc, exp);
    end
    @(posedge clock);
    #1;
    tests_run++;
    if ({bus.busy, bus.valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL busy_start_no_relaunch: got %b expected 00", {bus.busy, bus.valid});
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_a, exp_b;
    int cyc;
    set_random();
    exp_a = expect_out(bus.c1x, bus.c1y, bus.c2x, bus.c2y, bus.d, bus.a, bus.f);
    bus.start = 1'b1;
    launch_and_wait(cyc);
    tests_run++;
    if ({bus.mx, bus.my, bus.inf, bus.busy} !== {exp_a, 1'b0} || cyc !== 26) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got %h busy=%b lat=%0d expected %h busy=0 lat=26",
               {bus.mx, bus.my, bus.inf}, bus.busy, cyc, exp_a);
    end
    set_random();
    exp_b = expect_out(bus.c1x, bus.c1y, bus.c2x, bus.c2y, bus.d, bus.a, bus.f);
    bus.start = 1'b1;
    launch_and_wait(cyc);
    tests_run++;
    if ({bus.mx, bus.my, bus.inf} !== exp_b || cyc !== 26) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got %h lat=%0d expected %h lat=26", {bus.mx, bus.my, bus.inf}, cyc, exp_b);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_round_trip();
    test_random();
    test_reset_mid_op();
    test_start_while_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
